uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that funnels bytes from N_REQ requesters into one UART TX.
// Optional SEND timeout, enabled by defining UART_TX_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int          N_REQ          = 4,
    parameter logic [29:0] TIMEOUT_CYCLES = 30'd50000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ-1:0][7:0] req_data,
    output logic [N_REQ-1:0]      req_ack,
    input  logic                  tx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    output logic [2:0]            grant_id,
    output logic                  busy,
    output logic                  tx_drop
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES == 30'd0) begin : g_bad_cfg
        $error("uart_tx_arbiter: N_REQ or TIMEOUT_CYCLES out of range");
    end

    state_t           state_q, state_d;
    logic [2:0]       rr_ptr_q, rr_ptr_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic [2:0]       grant_id_q, grant_id_d;
    logic [N_REQ-1:0] req_ack_q, req_ack_d;

    logic             found;
    logic [2:0]       win_id;
    logic [2:0]       win_nxt;
    logic [7:0]       win_data;
    logic [N_REQ-1:0] win_oh;
    logic [3:0]       slot;

`ifdef UART_TX_TIMEOUT_EN
    localparam logic [29:0] WAIT_LAST = TIMEOUT_CYCLES - 30'd1;

    logic [29:0] wait_q, wait_d;
    logic        tx_drop_q, tx_drop_d;
`endif

    // Round-robin search: visit slots rr_ptr, rr_ptr+1, ... with wrap.
    always_comb begin
        found    = 1'b0;
        win_id   = '0;
        win_nxt  = '0;
        win_data = '0;
        win_oh   = '0;
        slot     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            slot = {1'b0, rr_ptr_q} + 4'(k);
            if (slot >= 4'(N_REQ)) begin
                slot = slot - 4'(N_REQ);
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (!found && slot == 4'(i) && req_valid[i]) begin
                    found     = 1'b1;
                    win_id    = 3'(i);
                    win_nxt   = (i == N_REQ - 1) ? 3'd0 : 3'(i + 1);
                    win_data  = req_data[i];
                    win_oh    = '0;
                    win_oh[i] = 1'b1;
                end
            end
        end
    end

    // Next-state and registered-output logic for the IDLE/SEND machine.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        grant_id_d = grant_id_q;
        req_ack_d  = '0;
`ifdef UART_TX_TIMEOUT_EN
        wait_d     = wait_q;
        tx_drop_d  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                tx_valid_d = 1'b0;
                if (found) begin
                    state_d    = SEND;
                    tx_data_d  = win_data;
                    tx_valid_d = 1'b1;
                    grant_id_d = win_id;
                    req_ack_d  = win_oh;
                    rr_ptr_d   = win_nxt;
`ifdef UART_TX_TIMEOUT_EN
                    wait_d     = '0;
`endif
                end
            end
            SEND: begin
                if (tx_valid_q && tx_ready) begin
                    state_d    = IDLE;
                    tx_valid_d = 1'b0;
                end
`ifdef UART_TX_TIMEOUT_EN
                else if (wait_q == WAIT_LAST) begin
                    state_d    = IDLE;
                    tx_valid_d = 1'b0;
                    tx_drop_d  = 1'b1;
                end else begin
                    wait_d = wait_q + 30'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Main state and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            grant_id_q <= '0;
            req_ack_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            grant_id_q <= grant_id_d;
            req_ack_q  <= req_ack_d;
        end
    end

`ifdef UART_TX_TIMEOUT_EN
    // Wait counter and drop pulse for a byte stuck waiting on tx_ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_q    <= '0;
            tx_drop_q <= 1'b0;
        end else begin
            wait_q    <= wait_d;
            tx_drop_q <= tx_drop_d;
        end
    end

    assign tx_drop = tx_drop_q;
`else
    assign tx_drop = 1'b0;
`endif

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign grant_id = grant_id_q;
    assign req_ack  = req_ack_q;
    assign busy     = (state_q == SEND);

endmodule
